// File: rtl/vs_instruction_fetch_pkg.sv
// Shared widths and FSM encodings for the vertex-shader instruction fetch stage.
// Combinational definitions only: no latency, no backpressure.
package vs_instruction_fetch_pkg;
    localparam int INST_WIDTH         = 64;
    localparam int VS_IMEM_ADDR_WIDTH = 8;
    localparam int VS_PROG_LEN_WIDTH  = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/vs_instruction_fetch_if.sv
// Instruction RAM read port plus decode valid/ready link of the fetch stage.
// Wires only: no latency; decode backpressures through iReady.
interface vs_instruction_fetch_if
    import vs_instruction_fetch_pkg::*;
#(
    parameter int INST_W = INST_WIDTH,
    parameter int ADDR_W = VS_IMEM_ADDR_WIDTH
) ();
    logic              oImemRd;
    logic [ADDR_W-1:0] oImemAddr;
    logic [INST_W-1:0] iImemData;
    logic              oValid;
    logic [INST_W-1:0] oInstruction;
    logic              iReady;

    modport master (
        output oImemRd, oImemAddr, oValid, oInstruction,
        input  iImemData, iReady
    );
    modport slave (
        input  oImemRd, oImemAddr, oValid, oInstruction,
        output iImemData, iReady
    );
endinterface

// File: rtl/vs_fetch_queue.sv
// 2-entry FIFO holding returned instruction words; a push is visible at the head one cycle later.
// Push and pop may coincide when full; a push into a full queue without a pop is illegal.
module vs_fetch_queue
    import vs_instruction_fetch_pkg::*;
#(
    parameter int W = INST_WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign empty_o    = (count_q == 2'd0);
    assign full_o     = (count_q == 2'd2);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_d = count_q + 2'(do_push) - 2'(do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    ap_no_overflow: assert property (@(posedge clk) disable iff (!resetn || flush_i)
        !(push_i && full_o && !pop_i));
endmodule

// File: rtl/vs_instruction_fetch.sv
// Walks a vertex program in instruction RAM and feeds decode; iStart to first oValid is 3 cycles.
// Reads are throttled so RAM words in flight plus buffered never exceed the 2-entry queue.
module vs_instruction_fetch
    import vs_instruction_fetch_pkg::*;
#(
    parameter int INST_W = INST_WIDTH,
    parameter int ADDR_W = VS_IMEM_ADDR_WIDTH,
    parameter int LEN_W  = VS_PROG_LEN_WIDTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iProgBase,
    input  logic [LEN_W-1:0]  iProgLen,
    input  logic              iFlush,
    output logic              oBusy,
    output logic              oDone,
    vs_instruction_fetch_if.master bus
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  accepted_q, accepted_d;
    logic              inflight_q, inflight_d;

    logic              q_empty, q_full;
    logic [1:0]        q_count;
    logic [INST_W-1:0] q_head;
    logic              pop, issue;
    logic [2:0]        occ;

    assign pop = !q_empty && bus.iReady;
    // Slots committed after this cycle's pop; a new read may claim the remaining one.
    assign occ   = 3'(q_count) + 3'(inflight_q) - 3'(pop);
    assign issue = (state_q == ST_FETCH) && !iFlush && (occ < 3'd2) && (issued_q < len_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q + LEN_W'(pop);
        inflight_d = issue;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    ptr_d      = iProgBase;
                    len_d      = iProgLen;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (iProgLen == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    ptr_d    = ptr_q + ADDR_W'(1);
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_d == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && accepted_d == len_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (iFlush) begin
            state_d    = ST_IDLE;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
        end
    end

    vs_fetch_queue #(.W(INST_W)) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .flush_i    (iFlush),
        .push_i     (inflight_q && !iFlush),
        .push_dat_i (bus.iImemData),
        .pop_i      (pop),
        .head_dat_o (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

    assign bus.oImemRd      = issue;
    assign bus.oImemAddr    = ptr_q;
    assign bus.oValid       = !q_empty;
    assign bus.oInstruction = q_head;
    assign oBusy            = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign oDone            = (state_q == ST_DONE);

    ap_no_read_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(q_full && !pop && issue));
endmodule

// File: tb/tb_vs_instruction_fetch.sv
// Bench for vs_instruction_fetch: RAM model, program-level scoreboard checked every cycle,
// plus directed programs with literal timing/content expectations.
module tb_vs_instruction_fetch;
    import vs_instruction_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       resetn, iStart, iFlush, oBusy, oDone;
    logic [7:0] iProgBase;
    logic [8:0] iProgLen;
    int         checks = 0, failures = 0;

    vs_instruction_fetch_if bus ();

    vs_instruction_fetch dut (
        .clk       (clk),
        .resetn    (resetn),
        .iStart    (iStart),
        .iProgBase (iProgBase),
        .iProgLen  (iProgLen),
        .iFlush    (iFlush),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_word(input logic [7:0] a);
        return {8'hA5, 48'h0, a};
    endfunction

    logic [63:0] imem_dat = '0;
    always @(posedge clk) if (bus.oImemRd) imem_dat <= ram_word(bus.oImemAddr);
    assign bus.iImemData = imem_dat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // program-level model state
    logic [63:0] exp_words[$];
    logic [7:0]  exp_addrs[$];
    bit          idle_m = 1, busy_m = 0, done_m = 0, inval_m = 0, stall_m = 0, rst_last = 0;
    logic [63:0] stall_word;
    int          remaining = 0, issued_m = 0, accepted_m = 0, cyc = 0;
    // per-program observation log for literal checks
    logic [7:0]  rd_log[$];
    int          start_cyc = 0, first_rd_rel = -1, first_vld_rel = -1, done_rel = -1;
    int          acc_cnt = 0, done_cnt = 0;
    bit          busy_seen = 0;
    logic [63:0] first_word = '0;

    always @(negedge clk) begin
        bit pop, done_nxt;
        cyc++;
        if (!rst_last) begin
            check("rst_rd",   bus.oImemRd, 0);
            check("rst_addr", bus.oImemAddr, 0);
            check("rst_vld",  bus.oValid, 0);
            check("rst_inst", bus.oInstruction, 0);
            check("rst_busy", oBusy, 0);
            check("rst_done", oDone, 0);
            exp_words.delete(); exp_addrs.delete();
            idle_m = 1; busy_m = 0; done_m = 0; inval_m = 0; stall_m = 0;
            issued_m = 0; accepted_m = 0; remaining = 0;
        end else begin
            pop = bus.oValid && bus.iReady;
            if (bus.oImemRd) begin
                check("rd_pending", exp_addrs.size() > 0, 1);
                if (exp_addrs.size() > 0) check("rd_addr", bus.oImemAddr, exp_addrs.pop_front());
                rd_log.push_back(bus.oImemAddr);
                if (first_rd_rel < 0) first_rd_rel = cyc - start_cyc;
                issued_m++;
            end
            if (inval_m) check("flush_vld", bus.oValid, 0);
            if (stall_m) begin
                check("stall_vld", bus.oValid, 1);
                check("stall_inst", bus.oInstruction, stall_word);
            end
            if (pop) begin
                check("pop_pending", exp_words.size() > 0, 1);
                if (exp_words.size() > 0) check("word", bus.oInstruction, exp_words.pop_front());
                if (first_vld_rel < 0) begin
                    first_vld_rel = cyc - start_cyc;
                    first_word    = bus.oInstruction;
                end
                acc_cnt++;
                accepted_m++;
            end
            check("occupancy", (issued_m - accepted_m) <= 2, 1);
            check("done", oDone, done_m);
            check("busy", oBusy, busy_m);
            if (oDone) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
            if (oBusy) busy_seen = 1;

            done_nxt = 0;
            if (resetn) begin
                if (iFlush) begin
                    exp_words.delete(); exp_addrs.delete();
                    idle_m = 1; busy_m = 0; issued_m = 0; accepted_m = 0;
                end else begin
                    if (pop && busy_m) begin
                        remaining--;
                        if (remaining == 0) begin
                            busy_m   = 0;
                            done_nxt = 1;
                        end
                    end
                    if (done_m) idle_m = 1;
                    else if (iStart && idle_m) begin
                        idle_m = 0; start_cyc = cyc;
                        rd_log.delete(); first_rd_rel = -1; first_vld_rel = -1; done_rel = -1;
                        acc_cnt = 0; done_cnt = 0; busy_seen = 0; first_word = '0;
                        issued_m = 0; accepted_m = 0;
                        if (iProgLen == 0) done_nxt = 1;
                        else begin
                            busy_m    = 1;
                            remaining = int'(iProgLen);
                            for (int i = 0; i < int'(iProgLen); i++) begin
                                logic [7:0] a;
                                a = iProgBase + 8'(i);
                                exp_addrs.push_back(a);
                                exp_words.push_back(ram_word(a));
                            end
                        end
                    end
                end
            end
            done_m     = done_nxt;
            inval_m    = iFlush;
            stall_m    = bus.oValid && !bus.iReady && !iFlush;
            stall_word = bus.oInstruction;
        end
        rst_last = resetn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] b, input logic [8:0] l);
        iStart = 1'b1; iProgBase = b; iProgLen = l;
        tick();
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin
            tick();
            n++;
        end
        check({name, "_done_cnt"}, done_cnt, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; iStart = 1'b0; iFlush = 1'b0;
        iProgBase = '0; iProgLen = '0; bus.iReady = 1'b1;
        tick(); tick();
        resetn = 1'b1;
        tick();

        // straight-line program, decode always ready
        start(8'h10, 9'd4);
        wait_done("t1", 40);
        check("t1_rd_cnt", rd_log.size(), 4);
        check("t1_rd0", rd_log[0], 8'h10);
        check("t1_rd3", rd_log[3], 8'h13);
        check("t1_rd_lat", first_rd_rel, 1);
        check("t1_vld_lat", first_vld_rel, 3);
        check("t1_word0", first_word, 64'hA500_0000_0000_0010);
        check("t1_done_lat", done_rel, 7);

        // address wrap
        start(8'hFE, 9'd4);
        wait_done("t2", 40);
        check("t2_rd2", rd_log[2], 8'h00);
        check("t2_rd3", rd_log[3], 8'h01);
        check("t2_acc", acc_cnt, 4);

        // stalling decode 1,0,0,1
        start(8'h60, 9'd8);
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            bus.iReady = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        bus.iReady = 1'b1;
        check("t3_done_cnt", done_cnt, 1);
        check("t3_acc", acc_cnt, 8);
        tick();

        // zero-length program
        start(8'h40, 9'd0);
        wait_done("t4", 10);
        check("t4_done_lat", done_rel, 1);
        check("t4_rd_cnt", rd_log.size(), 0);
        check("t4_busy_seen", busy_seen, 0);

        // flush after two accepted words, then a fresh program
        start(8'h20, 9'd6);
        for (int i = 0; i < 20 && acc_cnt < 2; i++) tick();
        check("t5_acc_pre", acc_cnt, 2);
        bus.iReady = 1'b0; iFlush = 1'b1;
        tick();
        iFlush = 1'b0; bus.iReady = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_done", done_cnt, 0);
        check("t5_acc_post", acc_cnt, 2);
        start(8'h80, 9'd3);
        wait_done("t5b", 40);
        check("t5b_acc", acc_cnt, 3);
        check("t5b_word0", first_word, 64'hA500_0000_0000_0080);

        // reset mid-DRAIN; a start while busy must be ignored
        bus.iReady = 1'b0;
        start(8'h30, 9'd2);
        for (int i = 0; i < 4; i++) tick();
        start(8'hC0, 9'd3);
        tick(); tick();
        check("t6_rd_cnt", rd_log.size(), 2);
        check("t6_busy", oBusy, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        check("t6_rd_cnt_post", rd_log.size(), 2);
        bus.iReady = 1'b1;
        start(8'h50, 9'd2);
        wait_done("t6b", 40);
        check("t6b_acc", acc_cnt, 2);
        check("t6b_word0", first_word, 64'hA500_0000_0000_0050);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
